// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command path: byte/field widths, field
// positions within the received byte, and the decoder state encoding.
package uart_cmd_pkg;

    localparam int DATA_W = 8;
    localparam int OPC_W  = 2;
    localparam int OPR_W  = 3;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 6;
    localparam int OP1_MSB = 5;
    localparam int OP1_LSB = 3;
    localparam int OP2_MSB = 2;
    localparam int OP2_LSB = 0;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

endpackage

// File: rtl/uart_cmd_decoder.sv
// Splits one received UART byte into opcode/operand fields and holds it as a
// single pending command until the executor acknowledges it.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W = uart_cmd_pkg::DATA_W,
    parameter int OPC_W  = uart_cmd_pkg::OPC_W,
    parameter int OPR_W  = uart_cmd_pkg::OPR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic              cmd_ack,
    input  logic [DATA_W-1:0] data,
    output logic              cmd_valid,
    output logic [OPC_W-1:0]  opcode,
    output logic [OPR_W-1:0]  operand1,
    output logic [OPR_W-1:0]  operand2
);

    logic [0:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [OPR_W-1:0] op1_q, op1_d;
    logic [OPR_W-1:0] op2_q, op2_d;
    logic             capture_s;

    // Next-state and field capture; a byte is taken only when the slot is free
    // or is being freed by an ack in the same cycle.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    capture_s = 1'b1;
                    state_d   = ST_PENDING;
                    valid_d   = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                end
            end
            ST_PENDING: begin
                if (cmd_ack && rx_valid) begin
                    capture_s = 1'b1;
                    state_d   = ST_PENDING;
                    valid_d   = 1'b1;
                end else if (cmd_ack) begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                end else begin
                    state_d   = ST_PENDING;
                    valid_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (capture_s) begin
            opc_d = data[OPC_MSB:OPC_LSB];
            op1_d = data[OP1_MSB:OP1_LSB];
            op2_d = data[OP2_MSB:OP2_LSB];
        end else begin
            opc_d = opc_q;
            op1_d = op1_q;
            op2_d = op2_q;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            opc_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    assign cmd_valid = valid_q;
    assign opcode    = opc_q;
    assign operand1  = op1_q;
    assign operand2  = op2_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed scenarios followed by
// randomized rx/ack traffic compared against a one-slot command model.
module tb_uart_cmd_decoder;

    logic       clk;
    logic       reset;
    logic       rx_valid;
    logic       cmd_ack;
    logic [7:0] data;
    logic       cmd_valid;
    logic [1:0] opcode;
    logic [2:0] operand1;
    logic [2:0] operand2;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one command slot plus the last captured byte.
    logic       m_pend;
    logic [7:0] m_byte;

    uart_cmd_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .cmd_ack  (cmd_ack),
        .data     (data),
        .cmd_valid(cmd_valid),
        .opcode   (opcode),
        .operand1 (operand1),
        .operand2 (operand2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, int'(cmd_valid), int'(m_pend));
        check({tag, ".opc"},   int'(opcode),    int'(m_byte / 64));
        check({tag, ".op1"},   int'(operand1),  int'((m_byte / 8) % 8));
        check({tag, ".op2"},   int'(operand2),  int'(m_byte % 8));
    endtask

    task automatic step(input logic rxv, input logic ack, input logic [7:0] d,
                        input string tag);
        rx_valid = rxv;
        cmd_ack  = ack;
        data     = d;
        @(posedge clk);
        if (rxv && (!m_pend || ack)) begin
            m_byte = d;
            m_pend = 1'b1;
        end else if (ack) begin
            m_pend = 1'b0;
        end
        #1;
        rx_valid = 1'b0;
        cmd_ack  = 1'b0;
        data     = 8'h00;
        check_model(tag);
    endtask

    initial begin
        logic       rxv;
        logic       ack;
        logic [7:0] d;

        reset    = 1'b0;
        rx_valid = 1'b0;
        cmd_ack  = 1'b0;
        data     = 8'h00;
        m_pend   = 1'b0;
        m_byte   = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", int'(cmd_valid), 0);
        check("reset.fields", int'({opcode, operand1, operand2}), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        step(1'b1, 1'b0, 8'hAA, "basic.cap");
        check("basic.fields", int'({opcode, operand1, operand2}), int'({2'b10, 3'b101, 3'b010}));
        step(1'b0, 1'b0, 8'h00, "basic.hold");
        step(1'b0, 1'b1, 8'h00, "basic.ack");
        check("basic.ack.valid", int'(cmd_valid), 0);
        check("basic.ack.fields", int'({opcode, operand1, operand2}), int'({2'b10, 3'b101, 3'b010}));

        step(1'b1, 1'b0, 8'hAA, "drop.cap");
        step(1'b1, 1'b0, 8'h1F, "drop.rx");
        check("drop.fields", int'({opcode, operand1, operand2}), int'({2'b10, 3'b101, 3'b010}));
        step(1'b0, 1'b1, 8'h00, "drop.ack");
        check("drop.ack.valid", int'(cmd_valid), 0);

        step(1'b1, 1'b0, 8'hAA, "simul.cap");
        step(1'b1, 1'b1, 8'hC7, "simul.both");
        check("simul.valid", int'(cmd_valid), 1);
        check("simul.fields", int'({opcode, operand1, operand2}), int'({2'b11, 3'b000, 3'b111}));
        step(1'b0, 1'b1, 8'h00, "simul.ack");

        step(1'b0, 1'b1, 8'h00, "idleack");
        check("idleack.valid", int'(cmd_valid), 0);

        // Several-cycle rx_valid: only the first byte is kept.
        step(1'b1, 1'b0, 8'h35, "hold.rx0");
        step(1'b1, 1'b0, 8'hE2, "hold.rx1");
        step(1'b1, 1'b0, 8'h9C, "hold.rx2");
        step(1'b0, 1'b1, 8'h00, "hold.ack");

        step(1'b1, 1'b0, 8'hFF, "arst.cap");
        #2;
        reset = 1'b0;
        #1;
        check("arst.valid", int'(cmd_valid), 0);
        check("arst.fields", int'({opcode, operand1, operand2}), 0);
        m_pend = 1'b0;
        m_byte = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_model("arst.after");

        for (int i = 0; i < 400; i++) begin
            rxv = ($urandom_range(0, 99) < 45);
            ack = ($urandom_range(0, 99) < 40);
            d   = 8'($urandom);
            step(rxv, ack, d, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
